// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and small helpers for the instruction fetch stage.
package fetch_unit_pkg;

  // Datapath widths
  localparam int word_w = 32;
  localparam int addr_w = 32;

  // Control encodings
  localparam logic rst_enable  = 1'b1;
  localparam logic rom_enable  = 1'b1;
  localparam logic rom_disable = 1'b0;

  // All-zero word and address, used for bubbles and reset values
  localparam logic [word_w-1:0] zero_word = 32'h0000_0000;
  localparam logic [addr_w-1:0] zero_addr = 32'h0000_0000;

  // Largest value of the delivered-instruction counter
  localparam logic [word_w-1:0] count_max = 32'hFFFF_FFFF;

  // Fixed pc stride between sequential instructions
  localparam logic [addr_w-1:0] pc_step = 32'h0000_0004;

  // Fetch FSM: idle until the first edge out of reset, then fetch forever
  typedef enum logic [0:0] {
    st_idle = 1'b0,
    st_run  = 1'b1
  } fsm_state_e;

  // Force a byte address onto a word boundary
  function automatic logic [addr_w-1:0] word_align(input logic [addr_w-1:0] addr);
    return {addr[addr_w-1:2], 2'b00};
  endfunction

  // Increment that sticks at the maximum instead of wrapping
  function automatic logic [word_w-1:0] sat_inc(input logic [word_w-1:0] value);
    logic [word_w-1:0] result;
    if (value == count_max) begin
      result = value;
    end else begin
      result = value + 32'h0000_0001;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  // Decode-side control
  logic              stall;
  logic              jump_en;
  logic [addr_w-1:0] jump_addr;
  logic              branch_en;
  logic [addr_w-1:0] branch_addr;

  // Instruction memory
  logic [word_w-1:0] inst_in;
  logic              ce;
  logic [addr_w-1:0] pc;

  // IF/ID register and statistics
  logic [addr_w-1:0] if_pc;
  logic [word_w-1:0] if_inst;
  logic              if_valid;
  logic [word_w-1:0] fetch_count;

  // Fetch unit view
  modport master (
    input  stall, jump_en, jump_addr, branch_en, branch_addr, inst_in,
    output ce, pc, if_pc, if_inst, if_valid, fetch_count
  );

  // Environment view (memory + decode)
  modport slave (
    output stall, jump_en, jump_addr, branch_en, branch_addr, inst_in,
    input  ce, pc, if_pc, if_inst, if_valid, fetch_count
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: idle/run FSM, memory enable and next-pc selection.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [addr_w-1:0] jump_addr,
  input  logic              branch_en,
  input  logic [addr_w-1:0] branch_addr,
  output logic              ce,
  output logic [addr_w-1:0] pc,
  output logic              redirect
);

  fsm_state_e        state_r;
  fsm_state_e        state_next_s;
  logic [addr_w-1:0] pc_r;
  logic [addr_w-1:0] pc_next_s;
  logic              ce_r;
  logic              redirect_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      state_r <= st_idle;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and next pc; jump outranks branch, stall freezes everything
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    redirect_s   = 1'b0;
    case (state_r)
      st_idle: begin
        state_next_s = st_run;
        pc_next_s    = pc_r;
      end
      st_run: begin
        state_next_s = st_run;
        if (stall) begin
          pc_next_s = pc_r;
        end else if (jump_en) begin
          pc_next_s  = word_align(jump_addr);
          redirect_s = 1'b1;
        end else if (branch_en) begin
          pc_next_s  = word_align(branch_addr);
          redirect_s = 1'b1;
        end else begin
          pc_next_s = pc_r + pc_step;
        end
      end
      default: begin
        state_next_s = st_idle;
        pc_next_s    = RESET_PC;
      end
    endcase
  end

  // Registered pc and memory enable; ce tracks the state being entered
  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      pc_r <= RESET_PC;
      ce_r <= rom_disable;
    end else begin
      pc_r <= pc_next_s;
      ce_r <= (state_next_s == st_run) ? rom_enable : rom_disable;
    end
  end

  assign ce       = ce_r;
  assign pc       = pc_r;
  assign redirect = redirect_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register plus IF/ID register and fetch counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic              ce_s;
  logic [addr_w-1:0] pc_s;
  logic              redirect_s;

  logic [addr_w-1:0] if_pc_r;
  logic [word_w-1:0] if_inst_r;
  logic              if_valid_r;
  logic [word_w-1:0] fetch_count_r;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall       (bus.stall),
    .jump_en     (bus.jump_en),
    .jump_addr   (bus.jump_addr),
    .branch_en   (bus.branch_en),
    .branch_addr (bus.branch_addr),
    .ce          (ce_s),
    .pc          (pc_s),
    .redirect    (redirect_s)
  );

  // IF/ID capture: bubble while idle, hold on stall, squash on redirect
  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      if_pc_r       <= zero_addr;
      if_inst_r     <= zero_word;
      if_valid_r    <= 1'b0;
      fetch_count_r <= zero_word;
    end else if (ce_s != rom_enable) begin
      if_pc_r       <= zero_addr;
      if_inst_r     <= zero_word;
      if_valid_r    <= 1'b0;
      fetch_count_r <= fetch_count_r;
    end else if (bus.stall) begin
      if_pc_r       <= if_pc_r;
      if_inst_r     <= if_inst_r;
      if_valid_r    <= if_valid_r;
      fetch_count_r <= fetch_count_r;
    end else if (redirect_s) begin
      if_pc_r       <= zero_addr;
      if_inst_r     <= zero_word;
      if_valid_r    <= 1'b0;
      fetch_count_r <= fetch_count_r;
    end else begin
      if_pc_r       <= pc_s;
      if_inst_r     <= bus.inst_in;
      if_valid_r    <= 1'b1;
      fetch_count_r <= sat_inc(fetch_count_r);
    end
  end

  assign bus.ce          = ce_s;
  assign bus.pc          = pc_s;
  assign bus.if_pc       = if_pc_r;
  assign bus.if_inst     = if_inst_r;
  assign bus.if_valid    = if_valid_r;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected IF state per edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Clock generation
  always #5 clk = ~clk;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  // Instruction memory contents: a scrambled function of the address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign bus0.inst_in = imem(bus0.pc);
  assign bus1.inst_in = imem(bus1.pc);

  // Second instance only runs straight-line fetch from the top of memory
  assign bus1.stall       = 1'b0;
  assign bus1.jump_en     = 1'b0;
  assign bus1.jump_addr   = 32'h0000_0000;
  assign bus1.branch_en   = 1'b0;
  assign bus1.branch_addr = 32'h0000_0000;

  fetch_unit dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic        m_ce;
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_if_valid;
  logic [31:0] m_cnt;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic j, input logic [31:0] ja,
                       input logic b, input logic [31:0] ba);
    bus0.stall       = s;
    bus0.jump_en     = j;
    bus0.jump_addr   = ja;
    bus0.branch_en   = b;
    bus0.branch_addr = ba;
  endtask

  // Predict the state after the coming edge, push it, clock, pop and compare
  task automatic step();
    exp_t e;
    exp_t got;
    e = '{m_ce, m_pc, m_if_pc, m_if_inst, m_if_valid, m_cnt};
    if (rst) begin
      e = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
    end else if (m_ce !== 1'b1) begin
      e.ce       = 1'b1;
      e.if_pc    = 32'h0000_0000;
      e.if_inst  = 32'h0000_0000;
      e.if_valid = 1'b0;
    end else if (bus0.stall) begin
      e.ce = 1'b1;
    end else if (bus0.jump_en || bus0.branch_en) begin
      e.pc       = (bus0.jump_en ? bus0.jump_addr : bus0.branch_addr) & 32'hFFFF_FFFC;
      e.if_pc    = 32'h0000_0000;
      e.if_inst  = 32'h0000_0000;
      e.if_valid = 1'b0;
    end else begin
      e.pc       = m_pc + 32'h0000_0004;
      e.if_pc    = m_pc;
      e.if_inst  = imem(m_pc);
      e.if_valid = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) e.cnt = m_cnt + 32'h0000_0001;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_value("sb_ce",       {31'h0, bus0.ce},       {31'h0, got.ce});
    check_value("sb_pc",       bus0.pc,                got.pc);
    check_value("sb_if_pc",    bus0.if_pc,             got.if_pc);
    check_value("sb_if_inst",  bus0.if_inst,           got.if_inst);
    check_value("sb_if_valid", {31'h0, bus0.if_valid}, {31'h0, got.if_valid});
    check_value("sb_count",    bus0.fetch_count,       got.cnt);
    m_ce       = got.ce;
    m_pc       = got.pc;
    m_if_pc    = got.if_pc;
    m_if_inst  = got.if_inst;
    m_if_valid = got.if_valid;
    m_cnt      = got.cnt;
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios followed by a random stall/redirect mix
  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (3) begin
      step();
      check_value("rst_ce",    {31'h0, bus0.ce}, 32'h0);
      check_value("rst_pc",    bus0.pc, 32'h0000_0000);
      check_value("rst_pc_hi", bus1.pc, 32'hFFFF_FFFC);
    end

    rst = 1'b0;
    step();
    check_value("run_ce",       {31'h0, bus0.ce}, 32'h1);
    check_value("run_pc",       bus0.pc, 32'h0000_0000);
    check_value("run_bubble",   {31'h0, bus0.if_valid}, 32'h0);
    check_value("hi_first_pc",  bus1.pc, 32'hFFFF_FFFC);

    step();
    check_value("first_pc",     bus0.pc, 32'h0000_0004);
    check_value("first_if_pc",  bus0.if_pc, 32'h0000_0000);
    check_value("first_inst",   bus0.if_inst, imem(32'h0000_0000));
    check_value("first_valid",  {31'h0, bus0.if_valid}, 32'h1);
    check_value("first_count",  bus0.fetch_count, 32'h1);
    check_value("wrap_pc",      bus1.pc, 32'h0000_0000);
    check_value("wrap_if_pc",   bus1.if_pc, 32'hFFFF_FFFC);

    repeat (3) step();
    check_value("seq_pc",       bus0.pc, 32'h0000_0010);
    check_value("seq_count",    bus0.fetch_count, 32'h4);

    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008);
    step();
    check_value("br_pc",        bus0.pc, 32'h0000_0008);

    drive(1'b0, 1'b1, 32'h0000_0022, 1'b0, 32'h0);
    step();
    check_value("jmp_pc",       bus0.pc, 32'h0000_0020);
    check_value("jmp_valid",    {31'h0, bus0.if_valid}, 32'h0);
    check_value("jmp_inst",     bus0.if_inst, 32'h0);
    check_value("jmp_count",    bus0.fetch_count, 32'h4);

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_value("jmp_if_pc",    bus0.if_pc, 32'h0000_0020);
    check_value("jmp_count2",   bus0.fetch_count, 32'h5);

    drive(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);
    step();
    check_value("prio_pc",      bus0.pc, 32'h0000_0040);

    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_000C);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_value("pre_stall_pc", bus0.pc, 32'h0000_0010);

    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    repeat (2) begin
      step();
      check_value("stall_pc",    bus0.pc, 32'h0000_0010);
      check_value("stall_if_pc", bus0.if_pc, 32'h0000_000C);
      check_value("stall_count", bus0.fetch_count, 32'h6);
    end

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check_value("unstall_pc",   bus0.pc, 32'h0000_0014);

    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);
    step();
    check_value("midrst_pc",    bus0.pc, 32'h0000_0000);
    check_value("midrst_ce",    {31'h0, bus0.ce}, 32'h0);
    check_value("midrst_count", bus0.fetch_count, 32'h0);
    check_value("midrst_hi_pc", bus1.pc, 32'hFFFF_FFFC);

    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) step();

    for (int i = 0; i < 60; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom);
      step();
    end

    check_value("sb_empty", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, word-aligned address loaded into pc by reset.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall  input  1  hold request from downstream; 1 freezes pc and the IF/ID register.
REQ-005 SHALL have port: jump_en  input  1  jump/jal redirect request from decode.
REQ-006 SHALL have port: jump_addr  input  32  jump target byte address.
REQ-007 SHALL have port: branch_en  input  1  taken-branch redirect request from decode.
REQ-008 SHALL have port: branch_addr  input  32  branch target byte address.
REQ-009 SHALL have port: inst_in  input  32  instruction word returned combinationally by instruction memory for the current pc.
REQ-010 SHALL have port: ce  output  1  instruction-memory enable (RomEnable/RomDisable encoding).
REQ-011 SHALL have port: pc  output  32  current fetch address driven to instruction memory.
REQ-012 SHALL have port: if_pc  output  32  IF/ID register: address of the captured instruction.
REQ-013 SHALL have port: if_inst  output  32  IF/ID register: captured instruction word.
REQ-014 SHALL have port: if_valid  output  1  IF/ID register: 1 = if_inst is a real instruction, 0 = bubble.
REQ-015 SHALL have port: fetch_count  output  32  count of valid instructions delivered to decode.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (ce=0, pc held) and RUN (ce=1, fetching).
REQ-017 SHALL transition IDLE->RUN on the first rising edge with rst=0; RUN has no exit except reset.
REQ-018 SHALL fetch zero-latency: inst_in in cycle N belongs to pc in cycle N; it is captured into IF/ID at the end of cycle N.
REQ-019 SHALL, in RUN with stall=0 and no redirect: pc <= pc+4 (mod 2^32), if_pc <= pc, if_inst <= inst_in, if_valid <= 1.
REQ-020 SHALL, in RUN with stall=0 and jump_en=1: pc <= {jump_addr[31:2],2'b00}, and IF/ID flushed (if_pc <= 0, if_inst <= 0, if_valid <= 0).
REQ-021 SHALL, in RUN with stall=0, jump_en=0 and branch_en=1: pc <= {branch_addr[31:2],2'b00}, and IF/ID flushed as in REQ-020.
REQ-022 SHALL give jump_en priority over branch_en when both are asserted in the same cycle.
REQ-023 SHALL, with stall=1, hold pc, if_pc, if_inst, if_valid and fetch_count, and ignore jump_en/branch_en that cycle; decode re-presents the redirect.
REQ-024 SHALL hold IF/ID at bubble values (0/0/0) in IDLE.
REQ-025 SHALL increment fetch_count on every edge where if_valid is loaded with 1, saturating at 32'hFFFFFFFF.
REQ-026 SHALL implement no branch delay slot; the wrong-path instruction is squashed per REQ-020/021.
REQ-027 SHALL wrap pc from 32'hFFFFFFFC to 32'h00000000 without any flag.

Reset
REQ-028 SHALL, on any edge with rst=1 (including mid-operation): state <= IDLE, ce <= RomDisable, pc <= RESET_PC, if_pc <= 0, if_inst <= 0, if_valid <= 0, fetch_count <= 0.
REQ-029 SHALL give rst priority over stall, jump_en and branch_en.

Structure
REQ-030 SHALL take RstEnable, RomEnable, RomDisable, Zero and the 32-bit word/address widths from the shared define.v constants.
REQ-031 SHALL place the FSM state encodings (IDLE, RUN) in define.v alongside the existing constants.
REQ-032 SHALL split into a natural sub-module pc_reg (FSM, ce, pc, next-pc selection); fetch_unit adds the IF/ID register and fetch_count.

Verification
REQ-033 SHALL cover reset release: rst=1 for 3 cycles then 0 -> ce=0, pc=0 during reset; first edge after: ce=1, pc=0; next edge: pc=4, if_pc=0, if_inst=inst at addr 0, if_valid=1, fetch_count=1.
REQ-034 SHALL cover sequential fetch: 4 unstalled cycles -> pc 0,4,8,C,10; fetch_count reaches 4.
REQ-035 SHALL cover jump: pc=8, jump_en=1, jump_addr=0x22 -> next pc=0x20, if_valid=0, if_inst=0, fetch_count unchanged; following edge if_pc=0x20.
REQ-036 SHALL cover simultaneous jump_en (0x40) and branch_en (0x80) -> pc=0x40; and stall=1 with jump_en=1 at pc=0x10 for 2 cycles -> pc, IF/ID, fetch_count all held, redirect ignored.
REQ-037 SHALL cover wrap and mid-run reset: RESET_PC=32'hFFFFFFFC -> pc goes FFFFFFFC then 0; rst=1 asserted with pc=0x14 -> next edge pc=RESET_PC, ce=0, fetch_count=0.
